// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write-side arbiter in front of a synchronous FIFO. NUM_REQ
// producers share the FIFO's single write port through per-requester
// valid/ready handshakes. A grant is held for up to MAX_BURST accepted beats.
// An internal credit counter (occ) reserves an entry at acceptance and
// releases it on rd_done, so a write the FIFO would drop is never issued.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester data valid                      [NUM_REQ]
//   req_data   requester i data in bits [i*WIDTH +: WIDTH]   [NUM_REQ*WIDTH]
//   req_ready  per-requester accept (combinational from registered state,
//              occ and fifo_full)                            [NUM_REQ]
//   fifo_wr    registered write strobe to the FIFO
//   fifo_data  registered write data to the FIFO             [WIDTH]
//   fifo_full  FIFO full flag
//   rd_done    one-cycle pulse per entry popped from the FIFO
//   grant_id   current or most recent grantee                [$clog2(NUM_REQ)]
//   busy       high while in the GRANT state
//   occ        reserved/occupied entry count                 [$clog2(FIFO_CAP+1)]
//
// Optional build macro FIFO_WR_ARB_STATS_EN adds:
//   stats_clr  synchronous clear of stall_cnt (priority over increment)
//   stall_cnt  saturating count of cycles in GRANT where the grantee is valid
//              but not ready                                 [16]
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int FIFO_CAP  = 15,
   parameter int MAX_BURST = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]       req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           fifo_wr,
   output logic [WIDTH-1:0]               fifo_data,
   input  logic                           fifo_full,
   input  logic                           rd_done,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           busy,
   output logic [$clog2(FIFO_CAP+1)-1:0]  occ
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   input  logic                           stats_clr,
   output logic [15:0]                    stall_cnt
`endif
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int OW = $clog2(FIFO_CAP + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [BW-1:0]   burst_cnt;

   logic [GW-1:0]   next_gid;
   logic [GW-1:0]   cand;
   logic            found;
   logic            can_accept;
   logic            accept;
   logic            rd_eff;
   logic            burst_last;
   logic [WIDTH-1:0] sel_data;

   // Round-robin search: first valid requester strictly after grant_id,
   // wrapping from NUM_REQ-1 back to 0; grant_id itself is tried last.
   always_comb begin
      next_gid = grant_id;
      cand     = '0;
      found    = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(grant_id) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found    = 1'b1;
            next_gid = cand;
         end
      end
   end

   // Ready is withheld whenever the credit counter is exhausted or the FIFO
   // reports full; this also freezes the burst count during a stall.
   assign can_accept = (state == GRANT) && (occ < OW'(FIFO_CAP)) && !fifo_full;
   assign accept     = can_accept && req_valid[grant_id];
   // A spurious rd_done with nothing reserved must not underflow occ.
   assign rd_eff     = rd_done && (occ != '0);
   assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));
   assign sel_data   = req_data[int'(grant_id)*WIDTH +: WIDTH];

   always_comb begin
      req_ready = '0;
      if (can_accept) req_ready[grant_id] = 1'b1;
   end

   // ---- acceptance edge -> registered FIFO write (one cycle latency) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         grant_id  <= GW'(NUM_REQ - 1);
         burst_cnt <= '0;
         occ       <= '0;
         fifo_wr   <= 1'b0;
         fifo_data <= '0;
      end else begin
         fifo_wr <= accept;
         if (accept) fifo_data <= sel_data;

         // Credit is reserved at acceptance, before the write reaches the FIFO.
         case ({accept, rd_eff})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant_id  <= next_gid;
                  burst_cnt <= '0;
                  state     <= GRANT;
                  busy      <= 1'b1;
               end
            end
            GRANT: begin
               if (!req_valid[grant_id]) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (accept) begin
                  burst_cnt <= burst_cnt + 1'b1;
                  if (burst_last) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   // Stall statistics: grantee has data but credit or FIFO space is missing.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stats_clr) begin
         stall_cnt <= '0;
      end else if ((state == GRANT) && req_valid[grant_id] && !req_ready[grant_id]
                   && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. Producers are modelled per
// requester (beats remaining, next data value); every accepted beat pushes its
// data onto a scoreboard queue that is popped and compared on each fifo_wr.
// Scenario checks compare against constants derived from the intended
// behaviour. Build with FIFO_WR_ARB_STATS_EN defined to also exercise the
// stall counter.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 8;
   localparam int FIFO_CAP  = 15;
   localparam int MAX_BURST = 4;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*WIDTH-1:0]  req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_wr;
   logic [WIDTH-1:0]          fifo_data;
   logic                      fifo_full;
   logic                      rd_done;
   logic [1:0]                grant_id;
   logic                      busy;
   logic [3:0]                occ;
`ifdef FIFO_WR_ARB_STATS_EN
   logic                      stats_clr;
   logic [15:0]               stall_cnt;
`endif

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .WIDTH     (WIDTH),
      .FIFO_CAP  (FIFO_CAP),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .rd_done   (rd_done),
      .grant_id  (grant_id),
      .busy      (busy),
      .occ       (occ)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .stall_cnt (stall_cnt)
`endif
   );

   int          vectors     = 0;
   int          miscompares = 0;

   logic [7:0]  sb[$];
   int          beats_left[NUM_REQ];
   logic [7:0]  next_data[NUM_REQ];
   int          wr_cnt;
   int          beats_in_grant;
   int          idle_run;
   int          max_occ;
   int          glog[$];
   int          gbeats[$];
   int          ggap[$];
   logic        busy_q;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]             = (beats_left[i] > 0);
         req_data[i*WIDTH +: WIDTH] = next_data[i];
      end
   endtask

   // One clock: observe outputs mid-cycle, record handshakes at the edge,
   // then update producer stimulus just after the edge.
   task automatic tick();
      logic [NUM_REQ-1:0] hs;
      logic [7:0]         exp_d;
      @(negedge clk);
      hs = req_valid & req_ready;
      if (fifo_wr) begin
         wr_cnt++;
         if (sb.size() == 0) begin
            check_val("sb_underflow", sb.size(), 1);
         end else begin
            exp_d = sb.pop_front();
            check_val("wr_data", fifo_data, exp_d);
         end
      end
      check_val("occ_bound", (occ <= FIFO_CAP), 1);
      check_val("ready_onehot", ($countones(req_ready) <= 1), 1);
      check_val("ready_idle", (busy || (req_ready == '0)), 1);
      if (int'(occ) > max_occ) max_occ = occ;
      if (busy && !busy_q) begin
         glog.push_back(int'(grant_id));
         ggap.push_back(idle_run);
         beats_in_grant = 0;
      end
      if (!busy && busy_q) gbeats.push_back(beats_in_grant);
      idle_run = busy ? 0 : idle_run + 1;
      busy_q   = busy;
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
               sb.push_back(next_data[i]);
               next_data[i] = next_data[i] + 8'd1;
               beats_left[i]--;
               beats_in_grant++;
            end
         end
      end
      #1;
      apply_inputs();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      rd_done   = 1'b0;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) beats_left[i] = 0;
      apply_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      rd_done   = 1'b0;
      fifo_full = 1'b0;
      req_valid = '0;
      req_data  = '0;
      busy_q    = 1'b0;
      idle_run  = 0;
      wr_cnt    = 0;
      max_occ   = 0;
      beats_in_grant = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beats_left[i] = 0;
         next_data[i]  = 8'h00;
      end
`ifdef FIFO_WR_ARB_STATS_EN
      stats_clr = 1'b0;
`endif

      // ---- 1: single requester, one full burst ----
      do_reset();
      check_val("rst_fifo_wr", fifo_wr, 0);
      check_val("rst_fifo_data", fifo_data, 0);
      check_val("rst_occ", occ, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", req_ready, 0);
      check_val("rst_grant_id", grant_id, 3);
      wr_cnt = 0;
      beats_left[0] = 4;
      next_data[0]  = 8'hA0;
      apply_inputs();
      tick();
      check_val("t1_grant_id", grant_id, 0);
      check_val("t1_busy", busy, 1);
      check_val("t1_ready", req_ready, 4'b0001);
      repeat (4) tick();
      check_val("t1_idle_after_burst", busy, 0);
      check_val("t1_occ", occ, 4);
      tick();
      check_val("t1_writes", wr_cnt, 4);
      check_val("t1_sb_empty", sb.size(), 0);

      // ---- 2: all requesters, continuous drain, round-robin with wrap ----
      do_reset();
      glog.delete();
      gbeats.delete();
      ggap.delete();
      max_occ = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beats_left[i] = 100;
         next_data[i]  = 8'(8'h10 + 8'h30 * i);
      end
      rd_done = 1'b1;
      apply_inputs();
      for (int c = 0; c < 200 && glog.size() < 5; c++) tick();
      check_val("t2_grant_count", glog.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < glog.size()) check_val("t2_grant_order", glog[k], k % NUM_REQ);
      end
      check_val("t2_burst_count", gbeats.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < gbeats.size()) check_val("t2_beats_per_grant", gbeats[k], MAX_BURST);
      end
      for (int k = 1; k < 5; k++) begin
         if (k < ggap.size()) check_val("t2_idle_gap", ggap[k], 1);
      end
      check_val("t2_max_occ", max_occ, 1);
      for (int i = 0; i < NUM_REQ; i++) beats_left[i] = 0;
      apply_inputs();
      repeat (4) tick();
      check_val("t2_occ_drained", occ, 0);
      check_val("t2_sb_empty", sb.size(), 0);
      rd_done = 1'b0;

      // ---- 3: credit exhaustion and refill ----
      do_reset();
      wr_cnt = 0;
      beats_left[2] = 20;
      next_data[2]  = 8'h80;
      apply_inputs();
      repeat (40) tick();
      check_val("t3_writes_at_cap", wr_cnt, 15);
      check_val("t3_occ_full", occ, 15);
      check_val("t3_ready_low", req_ready, 0);
      check_val("t3_grant_held", busy, 1);
      check_val("t3_grant_id", grant_id, 2);
`ifdef FIFO_WR_ARB_STATS_EN
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      check_val("t3_stall_cleared", stall_cnt, 0);
      repeat (5) tick();
      check_val("t3_stall_cnt", stall_cnt, 5);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      check_val("t3_stall_clr", stall_cnt, 0);
`endif
      repeat (3) begin
         rd_done = 1'b1;
         tick();
         rd_done = 1'b0;
         repeat (6) tick();
      end
      check_val("t3_writes_after_rd", wr_cnt, 18);
      check_val("t3_occ_refilled", occ, 15);
      check_val("t3_sb_empty", sb.size(), 0);

      // ---- 4: fifo_full stall mid-burst, burst count frozen ----
      do_reset();
      beats_left[3] = 6;
      next_data[3]  = 8'hC0;
      apply_inputs();
      tick();
      repeat (3) tick();
      check_val("t4_occ_pre", occ, 3);
      check_val("t4_busy_pre", busy, 1);
      fifo_full = 1'b1;
      #1;
      check_val("t4_ready_full", req_ready, 0);
      repeat (5) tick();
      check_val("t4_no_write", fifo_wr, 0);
      check_val("t4_grant_held", busy, 1);
      check_val("t4_grant_id", grant_id, 3);
      check_val("t4_occ_frozen", occ, 3);
      fifo_full = 1'b0;
      tick();
      check_val("t4_burst_done", busy, 0);
      check_val("t4_occ_resume", occ, 4);
      repeat (6) tick();
      check_val("t4_occ_final", occ, 6);
      check_val("t4_sb_empty", sb.size(), 0);

      // ---- 5: reset mid-burst ----
      do_reset();
      beats_left[1] = 4;
      next_data[1]  = 8'h50;
      apply_inputs();
      tick();
      check_val("t5_grant_id", grant_id, 1);
      repeat (2) tick();
      check_val("t5_occ_pre", occ, 2);
      reset = 1'b1;
      tick();
      check_val("t5_rst_fifo_wr", fifo_wr, 0);
      check_val("t5_rst_occ", occ, 0);
      check_val("t5_rst_busy", busy, 0);
      check_val("t5_rst_grant_id", grant_id, 3);
      reset = 1'b0;
      tick();
      check_val("t5_regrant_id", grant_id, 1);
      check_val("t5_regrant_busy", busy, 1);
      repeat (5) tick();
      check_val("t5_occ_final", occ, 2);
      check_val("t5_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
